// File: rtl/feature_mem_db.sv
// Double-buffered feature-weight memory: weights stream serially into the shadow
// bank while the active bank drives every weight to the PE array in parallel.
module feature_mem_db #(
   parameter  int KERNEL_SIZE  = 3,
   parameter  int NUM_FEATURES = 10,
   parameter  int WEIGHT_W     = 2,
   localparam int KK           = KERNEL_SIZE * KERNEL_SIZE
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         load_start,
   input  logic                                         load_abort,
   input  logic                                         w_valid,
   input  logic signed [WEIGHT_W-1:0]                   w_data,
   output logic                                         w_ready,
   output logic                                         load_done,
   input  logic                                         swap_req,
   output logic                                         swap_ack,
   output logic                                         active_bank,
   output logic [NUM_FEATURES-1:0][KK-1:0][WEIGHT_W-1:0] weights_output
);

   localparam int EW = (KK > 1) ? $clog2(KK) : 1;
   localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam logic [EW-1:0] ELEM_LAST = EW'(KK - 1);
   localparam logic [FW-1:0] FEAT_LAST = FW'(NUM_FEATURES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_e;
   typedef logic [NUM_FEATURES-1:0][KK-1:0][WEIGHT_W-1:0] bank_t;

   state_e         state_q, state_d;
   logic [EW-1:0]  elem_q, elem_d;
   logic [FW-1:0]  feat_q, feat_d;
   logic           active_q, active_d;
   logic           ack_q, ack_d;
   logic           wr_en;
   logic           shadow;
   bank_t [1:0]    bank_q;

   assign shadow = ~active_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d   = state_q;
      elem_d    = elem_q;
      feat_d    = feat_q;
      active_d  = active_q;
      ack_d     = 1'b0;
      wr_en     = 1'b0;
      w_ready   = 1'b0;
      load_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               elem_d  = '0;
               feat_d  = '0;
            end
         end
         LOAD: begin
            w_ready = 1'b1;
            // Abort wins over a coincident transfer: nothing is written that cycle.
            if (load_abort) begin
               state_d = IDLE;
            end else if (w_valid) begin
               wr_en = 1'b1;
               if (elem_q == ELEM_LAST) begin
                  elem_d = '0;
                  if (feat_q == FEAT_LAST) begin
                     feat_d  = '0;
                     state_d = FULL;
                  end else begin
                     feat_d = feat_q + 1'b1;
                  end
               end else begin
                  elem_d = elem_q + 1'b1;
               end
            end
         end
         FULL: begin
            load_done = 1'b1;
            if (load_abort) begin
               state_d = IDLE;
            end else if (swap_req) begin
               active_d = ~active_q;
               ack_d    = 1'b1;
               elem_d   = '0;
               feat_d   = '0;
               state_d  = load_start ? LOAD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         elem_q   <= '0;
         feat_q   <= '0;
         active_q <= 1'b0;
         ack_q    <= 1'b0;
         // NOTE: the banks are reset too, because weights_output must read all zero out of reset.
         bank_q   <= '0;
      end else begin
         state_q  <= state_d;
         elem_q   <= elem_d;
         feat_q   <= feat_d;
         active_q <= active_d;
         ack_q    <= ack_d;
         if (wr_en) bank_q[shadow][feat_q][elem_q] <= w_data;
      end
   end

   assign swap_ack       = ack_q;
   assign active_bank    = active_q;
   assign weights_output = bank_q[active_q];

endmodule

// File: tb/tb_feature_mem_db.sv
// Scoreboard bench for feature_mem_db: the driver keeps a per-bank weight model and
// queues expected post-swap views; a negedge monitor pops and compares them.
module tb_feature_mem_db;

   localparam int KS = 3;
   localparam int NF = 10;
   localparam int W  = 2;
   localparam int KK = KS * KS;
   localparam int N  = NF * KK;
   localparam int WB = N * W;

   typedef logic [NF-1:0][KK-1:0][W-1:0] view_t;
   typedef struct packed {
      logic  active;
      view_t w;
   } swap_exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                load_start = 1'b0;
   logic                load_abort = 1'b0;
   logic                w_valid = 1'b0;
   logic signed [W-1:0] w_data = '0;
   logic                swap_req = 1'b0;
   logic                w_ready, load_done, swap_ack, active_bank;
   view_t               weights_output;

   int                  n_checks = 0;
   int                  n_pass = 0;
   logic [W-1:0]        m_bank [2][NF][KK];
   logic                m_active;
   int                  xfer_idx;
   swap_exp_t           swap_q[$];

   feature_mem_db #(.KERNEL_SIZE(KS), .NUM_FEATURES(NF), .WEIGHT_W(W)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .load_done(load_done),
      .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
      .weights_output(weights_output)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic view_t model_view(input logic b);
      view_t v;
      for (int f = 0; f < NF; f++)
         for (int e = 0; e < KK; e++)
            v[f][e] = m_bank[b][f][e];
      return v;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int f = 0; f < NF; f++)
            for (int e = 0; e < KK; e++)
               m_bank[b][f][e] = '0;
      m_active = 1'b0;
      xfer_idx = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      xfer_idx   = 0;
      check("w_ready_after_start", w_ready, 1'b1);
   endtask

   // vmode: 0 valid always, 1 alternating 1/0, 2 random. dmode: 0 (idx mod 4)-2, 1 all +1, 2 random.
   task automatic stream(input int n, input int vmode, input int dmode);
      int done;
      int cyc;
      logic v;
      logic [W-1:0] d;
      done = 0;
      cyc  = 0;
      while (done < n) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = ~cyc[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         case (dmode)
            0:       d = W'((xfer_idx % 4) - 2);
            1:       d = W'(1);
            default: d = W'($urandom_range(0, 3));
         endcase
         check("w_ready_load", w_ready, 1'b1);
         check("load_done_early", load_done, 1'b0);
         w_valid = v;
         w_data  = d;
         tick();
         if (v) begin
            m_bank[!m_active][xfer_idx / KK][xfer_idx % KK] = d;
            xfer_idx++;
            done++;
         end
         cyc++;
      end
      w_valid = 1'b0;
   endtask

   task automatic finish_load();
      check("load_done", load_done, 1'b1);
      check("w_ready_full", w_ready, 1'b0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("full_ignores_start", load_done, 1'b1);
   endtask

   task automatic do_swap(input logic with_start);
      swap_exp_t e;
      m_active = !m_active;
      e.active = m_active;
      e.w      = model_view(m_active);
      swap_q.push_back(e);
      swap_req   = 1'b1;
      load_start = with_start;
      tick();
      swap_req   = 1'b0;
      load_start = 1'b0;
      xfer_idx   = 0;
      check("swap_ack_pulse", swap_ack, 1'b1);
      check("active_after_swap", active_bank, m_active);
      check("w_ready_after_swap", w_ready, with_start);
      check("load_done_after_swap", load_done, 1'b0);
   endtask

   task automatic swap_refused(input string name);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      check(name, swap_ack, 1'b0);
   endtask

   initial begin : monitor
      view_t     view;
      logic      view_active;
      int        hs;
      logic      prev_done;
      swap_exp_t e;
      view        = '0;
      view_active = 1'b0;
      hs          = 0;
      prev_done   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            view        = '0;
            view_active = 1'b0;
            hs          = 0;
            prev_done   = 1'b0;
            swap_q.delete();
         end else begin
            if (swap_ack) begin
               if (swap_q.size() == 0) begin
                  check("spurious_swap_ack", swap_ack, 1'b0);
               end else begin
                  e           = swap_q.pop_front();
                  view        = e.w;
                  view_active = e.active;
               end
            end
            check("active_bank_mon", active_bank, view_active);
            check("weights_output_mon", weights_output, view);
            if (load_done && !prev_done) begin
               check("xfer_count", hs, N);
               hs = 0;
            end
            if (load_abort) hs = 0;
            else if (w_valid && w_ready) hs++;
            prev_done = load_done;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      view_t ones;
      model_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_weights", weights_output, '0);
      check("reset_active", active_bank, 1'b0);
      check("reset_w_ready", w_ready, 1'b0);
      check("reset_load_done", load_done, 1'b0);
      check("reset_swap_ack", swap_ack, 1'b0);
      rst = 1'b1;
      tick();
      swap_refused("idle_ignores_swap");

      // Patterned load, continuous valid, then swap.
      start_load();
      stream(N, 0, 0);
      finish_load();
      check("weights_before_swap", weights_output, '0);
      do_swap(1'b0);
      check("w_0_0", weights_output[0][0], 2'b10);
      check("w_0_1", weights_output[0][1], 2'b11);
      check("w_9_8", weights_output[9][8], m_bank[1][9][8]);

      // Alternating valid, random data.
      start_load();
      stream(N, 1, 2);
      finish_load();
      do_swap(1'b0);

      // Full load abandoned in FULL: no swap may follow.
      start_load();
      stream(N, 2, 2);
      finish_load();
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      check("abort_full_done", load_done, 1'b0);
      check("abort_full_ready", w_ready, 1'b0);
      swap_refused("abort_full_no_swap");

      // Abort after 40 transfers (coincident with a valid beat), then a clean all +1 load.
      start_load();
      stream(40, 0, 2);
      load_abort = 1'b1;
      w_valid    = 1'b1;
      w_data     = 2'sb01;
      tick();
      load_abort = 1'b0;
      w_valid    = 1'b0;
      check("abort_load_ready", w_ready, 1'b0);
      swap_refused("abort_load_no_swap");
      start_load();
      stream(N, 0, 1);
      finish_load();
      do_swap(1'b0);
      for (int f = 0; f < NF; f++)
         for (int k = 0; k < KK; k++)
            ones[f][k] = 2'b01;
      check("all_plus_one", weights_output, ones);

      // Back-to-back: swap and load_start together, reload into the new shadow bank.
      start_load();
      stream(N, 2, 2);
      finish_load();
      do_swap(1'b1);
      stream(N, 2, 2);
      finish_load();
      do_swap(1'b0);
      check("bank1_active", active_bank, 1'b1);

      // Reset in the middle of a load.
      start_load();
      stream(30, 0, 2);
      rst = 1'b0;
      #1;
      check("midreset_active", active_bank, 1'b0);
      check("midreset_weights", weights_output, '0);
      check("midreset_w_ready", w_ready, 1'b0);
      check("midreset_load_done", load_done, 1'b0);
      check("midreset_swap_ack", swap_ack, 1'b0);
      model_reset();
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Recovery after reset.
      start_load();
      stream(N, 1, 2);
      finish_load();
      do_swap(1'b0);
      repeat (3) tick();
      check("swap_q_drained", swap_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
